alu_array: RTL

ALU_ARRAY -- requirements
Module: alu_array

---
 rtl/alu_array_pkg.sv | 21 ++
 rtl/alu_array_alu_4B.sv | 24 ++
 rtl/alu_array.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_array_pkg.sv
// Shared opcode constants and geometry for the per-stage ALU array.
package alu_array_pkg;

    localparam int CONT_W    = 32;
    localparam int NUM_CONT  = 64;
    localparam int OP_MSB    = 63;
    localparam int OP_LSB    = 56;
    localparam int OP_W      = OP_MSB - OP_LSB + 1;
    localparam int MEM_DEPTH = 32;
    localparam int MEM_AW    = 5;

    localparam logic [OP_W-1:0] OP_ADD   = 8'h01;
    localparam logic [OP_W-1:0] OP_SUB   = 8'h02;
    localparam logic [OP_W-1:0] OP_STORE = 8'h07;
    localparam logic [OP_W-1:0] OP_LOAD  = 8'h08;
    localparam logic [OP_W-1:0] OP_ADDI  = 8'h09;
    localparam logic [OP_W-1:0] OP_SUBI  = 8'h0A;
    localparam logic [OP_W-1:0] OP_LOADD = 8'h0B;
    localparam logic [OP_W-1:0] OP_SET   = 8'h0E;

endpackage

// File: rtl/alu_array_alu_4B.sv
// Stateless per-container ALU; stateful and unknown opcodes pass the original value.
module alu_4B
    import alu_array_pkg::*;
#(
    parameter int W = CONT_W
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [W-1:0]    c,
    output logic [W-1:0]    res
);

    always_comb begin
        res = c;
        case (op)
            OP_ADD, OP_ADDI: res = a + b;
            OP_SUB, OP_SUBI: res = a - b;
            OP_SET:          res = b;
            default:         res = c;
        endcase
    end

endmodule

// File: rtl/alu_array.sv
// One match-action stage ALU: 64 stateless container ALUs plus a 32-entry
// register file reachable only from the stateful slot, with a 1-deep output stage.
module alu_array
    import alu_array_pkg::*;
#(
    parameter int STAGE_ID      = 0,
    parameter int PHV_LEN       = 4*8*64+256,
    parameter int ACT_LEN       = 64,
    parameter int C_NUM_PHVS    = 65,
    parameter int width_4B      = 32,
    parameter int STATEFUL_SLOT = 63
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_in_valid,
    input  logic [width_4B*64-1:0]        alu_in_4B_1,
    input  logic [width_4B*64-1:0]        alu_in_4B_2,
    input  logic [width_4B*64-1:0]        alu_in_4B_3,
    input  logic [255:0]                  phv_remain_data,
    input  logic [ACT_LEN*C_NUM_PHVS-1:0] action_in,
    input  logic                          action_in_valid,
    output logic                          ready_out,
    output logic [PHV_LEN-1:0]            phv_out,
    output logic                          phv_out_valid,
    input  logic                          ready_in
);

    logic [C_NUM_PHVS-1:0][ACT_LEN-1:0] sub_act;
    logic [NUM_CONT-1:0][OP_W-1:0]      op;
    logic [NUM_CONT-1:0][width_4B-1:0]  a, b, c, alu_res, res;

    logic [width_4B-1:0] mem [MEM_DEPTH];
    logic [OP_W-1:0]     st_op;
    logic [MEM_AW-1:0]   st_addr;
    logic [width_4B-1:0] st_rd, st_sum, st_res;
    logic                accept;

    assign ready_out = ~phv_out_valid | ready_in;
    assign accept    = alu_in_valid & ready_out;

    assign a = alu_in_4B_1;
    assign b = alu_in_4B_2;
    assign c = alu_in_4B_3;

    // Sub-action 0 sits in the top slice of action_in and is not used here.
    for (genvar k = 0; k < C_NUM_PHVS; k++) begin : g_sub
        assign sub_act[k] = action_in[ACT_LEN*C_NUM_PHVS-1-k*ACT_LEN -: ACT_LEN];
    end

    for (genvar i = 0; i < NUM_CONT; i++) begin : g_cont
        assign op[i] = sub_act[i+1][OP_MSB:OP_LSB];

        alu_4B #(.W(width_4B)) u_alu (
            .op  (op[i]),
            .a   (a[i]),
            .b   (b[i]),
            .c   (c[i]),
            .res (alu_res[i])
        );

        if (i == STATEFUL_SLOT) begin : g_st
            assign res[i] = st_res;
        end else begin : g_nst
            assign res[i] = alu_res[i];
        end
    end

    // Memory is written on the accepting edge and read combinationally, so a
    // back-to-back loadd to the same address already sees the previous update.
    assign st_op   = op[STATEFUL_SLOT];
    assign st_addr = b[STATEFUL_SLOT][MEM_AW-1:0];
    assign st_rd   = mem[st_addr];
    assign st_sum  = st_rd + a[STATEFUL_SLOT];

    always_comb begin
        st_res = alu_res[STATEFUL_SLOT];
        case (st_op)
            OP_LOAD:  st_res = st_rd;
            OP_LOADD: st_res = st_sum;
            default:  st_res = alu_res[STATEFUL_SLOT];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phv_out_valid <= 1'b0;
            phv_out       <= '0;
            for (int j = 0; j < MEM_DEPTH; j++) mem[j] <= '0;
        end else begin
            if (accept) begin
                phv_out_valid <= 1'b1;
                phv_out       <= {res, phv_remain_data};
            end else if (ready_in) begin
                phv_out_valid <= 1'b0;
            end

            if (accept && st_op == OP_STORE)
                mem[st_addr] <= a[STATEFUL_SLOT];
            else if (accept && st_op == OP_LOADD)
                mem[st_addr] <= st_sum;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{action_in_valid, sub_act, 32'(STAGE_ID)};

endmodule
